// File: rtl/spike_pkg.sv
// Shared constants for the spike stream converter: frame markers, FSM states
// and the timestep status codes driven on ts_switch.
package spike_pkg;

    localparam logic [15:0] SOF_IDX_DEF = 16'hF1FA;
    localparam logic [15:0] SOF_BMP_DEF = 16'hF1FB;
    localparam logic [15:0] EOF_DEF     = 16'hFAF1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_IDX,
        ST_RUN_BMP,
        ST_EXPAND,
        ST_CLOSE
    } state_e;

    localparam logic [1:0] TS_IDLE  = 2'b00;
    localparam logic [1:0] TS_OPEN  = 2'b10;
    localparam logic [1:0] TS_CLOSE = 2'b11;

    function automatic logic [1:0] ts_code(input state_e s);
        case (s)
            ST_RUN_IDX, ST_RUN_BMP, ST_EXPAND: ts_code = TS_OPEN;
            ST_CLOSE:                          ts_code = TS_CLOSE;
            default:                           ts_code = TS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/spike_word_assembler.sv
// Packs UART bytes little-endian into IDX_W-bit words; a partial word left idle
// for TIMEOUT_CYC cycles is thrown away and reported with a one-cycle pulse.
module spike_word_assembler #(
    parameter int IDX_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             word_valid,
    output logic [IDX_W-1:0] word_data,
    output logic             timeout
);

    localparam int NB    = IDX_W / 8;
    localparam int CNT_W = $clog2(NB);
    localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NB - 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] buf_q, buf_d;
    logic [AGE_W-1:0] age_q, age_d;

    always_comb begin
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        age_d      = age_q;
        word_valid = 1'b0;
        timeout    = 1'b0;
        // The final byte goes straight to the output so the word is ready on its arrival cycle.
        word_data                  = buf_q;
        word_data[IDX_W-1 -: 8]    = rx_data;
        if (rx_valid) begin
            age_d = '0;
            if (cnt_q == LAST) begin
                word_valid = 1'b1;
                cnt_d      = '0;
                buf_d      = '0;
            end else begin
                buf_d[cnt_q*8 +: 8] = rx_data;
                cnt_d               = cnt_q + CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            if (age_q == AGE_MAX) begin
                timeout = 1'b1;
                cnt_d   = '0;
                buf_d   = '0;
                age_d   = '0;
            end else begin
                age_d = age_q + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            buf_q <= '0;
            age_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/spike_stream_converter.sv
// Turns a UART byte stream of framed spike indices or spike bitmaps into
// per-channel FIFO writes, with frame markers broadcast to every channel.
module spike_stream_converter
    import spike_pkg::*;
#(
    parameter int               IDX_W       = 16,
    parameter int               N_CH        = 2,
    parameter logic [IDX_W-1:0] SOF_IDX     = IDX_W'(SOF_IDX_DEF),
    parameter logic [IDX_W-1:0] SOF_BMP     = IDX_W'(SOF_BMP_DEF),
    parameter logic [IDX_W-1:0] EOF         = IDX_W'(EOF_DEF),
    parameter int               TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [N_CH*IDX_W-1:0] out_data,
    output logic [N_CH-1:0]       out_wr,
    input  logic [N_CH-1:0]       out_afull,
    output logic [1:0]            ts_switch,
    output logic [15:0]           frame_cnt,
    input  logic                  err_clr,
    output logic                  err_overrun,
    output logic                  err_frame,
    output logic                  err_timeout
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]  CH_MASK = CH_W'(N_CH - 1);
    localparam logic [IDX_W-1:0] IDX_W_L = IDX_W'(IDX_W);

    logic             aw_vld, aw_tmo;
    logic [IDX_W-1:0] aw_data;

    spike_word_assembler #(
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .word_valid (aw_vld),
        .word_data  (aw_data),
        .timeout    (aw_tmo)
    );

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            hold_q, hold_d;
    logic                        hold_vld_q, hold_vld_d;
    logic [IDX_W-1:0]            exp_q, exp_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;
    logic [N_CH-1:0]             wr_q, wr_d;
    logic [N_CH-1:0][IDX_W-1:0]  odata_q, odata_d;
    logic                        ovr_q, ovr_d, ferr_q, ferr_d, tmo_q, tmo_d;

    logic                        consume, ovr_evt, ferr_evt, all_clear;
    logic [CH_W-1:0]             word_ch, exp_ch;
    logic [IDX_W-1:0]            bit_idx, exp_idx;

    assign all_clear = (out_afull == '0);
    assign word_ch   = hold_q[CH_W-1:0] & CH_MASK;

    // Lowest set bit of the bitmap still being expanded, and the index it maps to.
    always_comb begin
        bit_idx = '0;
        for (int i = IDX_W - 1; i >= 0; i--) begin
            if (exp_q[i]) bit_idx = IDX_W'(i);
        end
        exp_idx = k_q * IDX_W_L + bit_idx;
        exp_ch  = exp_idx[CH_W-1:0] & CH_MASK;
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        exp_d       = exp_q;
        k_d         = k_q;
        frame_cnt_d = frame_cnt_q;
        wr_d        = '0;
        odata_d     = '0;
        consume     = 1'b0;
        ovr_evt     = 1'b0;
        ferr_evt    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_vld_q) begin
                    if (hold_q == SOF_IDX || hold_q == SOF_BMP) begin
                        if (all_clear) begin
                            wr_d    = '1;
                            for (int c = 0; c < N_CH; c++) odata_d[c] = hold_q;
                            consume = 1'b1;
                            k_d     = '0;
                            state_d = (hold_q == SOF_IDX) ? ST_RUN_IDX : ST_RUN_BMP;
                        end
                    end else begin
                        consume  = 1'b1;
                        ferr_evt = 1'b1;
                    end
                end
            end
            ST_RUN_IDX, ST_RUN_BMP: begin
                if (hold_vld_q) begin
                    if (hold_q == EOF) begin
                        consume = 1'b1;
                        state_d = ST_CLOSE;
                    end else if (hold_q == SOF_IDX || hold_q == SOF_BMP) begin
                        consume  = 1'b1;
                        ferr_evt = 1'b1;
                    end else if (state_q == ST_RUN_IDX) begin
                        if (!out_afull[word_ch]) begin
                            wr_d[word_ch]    = 1'b1;
                            odata_d[word_ch] = hold_q;
                            consume          = 1'b1;
                        end
                    end else if (hold_q == '0) begin
                        consume = 1'b1;
                        k_d     = k_q + IDX_W'(1);
                    end else begin
                        exp_d   = hold_q;
                        state_d = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                if (!out_afull[exp_ch]) begin
                    wr_d[exp_ch]    = 1'b1;
                    odata_d[exp_ch] = exp_idx;
                    exp_d           = exp_q & (exp_q - IDX_W'(1));
                    if (exp_d == '0) begin
                        consume = 1'b1;
                        k_d     = k_q + IDX_W'(1);
                        state_d = ST_RUN_BMP;
                    end
                end
            end
            ST_CLOSE: begin
                if (all_clear) begin
                    wr_d        = '1;
                    for (int c = 0; c < N_CH; c++) odata_d[c] = EOF;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word arriving on the cycle the held word leaves still finds room.
        if (consume) hold_vld_d = 1'b0;
        if (aw_vld) begin
            if (hold_vld_d) begin
                ovr_evt = 1'b1;
            end else begin
                hold_d     = aw_data;
                hold_vld_d = 1'b1;
            end
        end

        ovr_d  = (ovr_q  & ~err_clr) | ovr_evt;
        ferr_d = (ferr_q & ~err_clr) | ferr_evt;
        tmo_d  = (tmo_q  & ~err_clr) | aw_tmo;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            exp_q       <= '0;
            k_q         <= '0;
            frame_cnt_q <= '0;
            wr_q        <= '0;
            odata_q     <= '0;
            ovr_q       <= 1'b0;
            ferr_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            exp_q       <= exp_d;
            k_q         <= k_d;
            frame_cnt_q <= frame_cnt_d;
            wr_q        <= wr_d;
            odata_q     <= odata_d;
            ovr_q       <= ovr_d;
            ferr_q      <= ferr_d;
            tmo_q       <= tmo_d;
        end
    end

    assign out_data    = odata_q;
    assign out_wr      = wr_q;
    assign ts_switch   = ts_code(state_q);
    assign frame_cnt   = frame_cnt_q;
    assign err_overrun = ovr_q;
    assign err_frame   = ferr_q;
    assign err_timeout = tmo_q;

endmodule
